// File: rtl/pattern_serial_tx.sv
// Serial frame transmitter for the 8-in/8-out user slot: start bit, five data
// bits LSB-first, parity bit, stop bit, each held for CLKS_PER_BIT clocks.
module pattern_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(CLKS_PER_BIT - 1);

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] data;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];
    assign start = io_in[2];
    assign data  = io_in[7:3];

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] shift_q, shift_d;
    logic       start_q;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       par_q, par_d;
    logic       tgl_q, tgl_d;

    logic start_edge;
    logic bit_end;

    assign start_edge = start && !start_q;
    assign bit_end    = (cnt_q == LAST_CNT);

    // State, timing and every output are registered together on the rising
    // edge; reset forces the line idle-high immediately, mid-frame or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            shift_q   <= 5'd0;
            start_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_idx_q <= 3'd0;
            par_q     <= 1'b0;
            tgl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            start_q   <= start;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bit_idx_q <= bit_idx_d;
            par_q     <= par_d;
            tgl_q     <= tgl_d;
        end
    end

    // Edges that arrive outside IDLE (including on the final stop cycle) are
    // simply never looked at, so they are dropped rather than queued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start_edge) state_d = START;
            START:  if (bit_end) state_d = DATA;
            DATA:   if (bit_end && bit_idx_q == 3'd4) state_d = PARITY;
            PARITY: if (bit_end) state_d = STOP;
            STOP:   if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; tx for the following bit is
    // prepared on the last cycle of the current one so it switches on time.
    always_comb begin
        cnt_d     = bit_end ? 4'd0 : cnt_q + 4'd1;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bit_idx_d = bit_idx_q;
        par_d     = par_q;
        tgl_d     = tgl_q;
        unique case (state_q)
            IDLE: begin
                cnt_d  = 4'd0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start_edge) begin
                    shift_d = data;
                    par_d   = (^data) ^ PARITY_ODD;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd4) begin
                        tx_d      = par_q;
                        bit_idx_d = 3'd0;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) tx_d = 1'b1;
            end
            STOP: begin
                if (bit_end) begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    tgl_d  = ~tgl_q;
                end
            end
            default: begin
                cnt_d  = 4'd0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign io_out = {tgl_q, par_q, bit_idx_q, done_q, busy_q, tx_q};

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Directed bench for pattern_serial_tx: a table of frames with hand-computed
// line patterns, plus dropped-edge, held-start and mid-frame reset sequences.
module tb_pattern_serial_tx;

    typedef struct {
        logic [4:0] data;
        logic [0:7] seq;
        logic       par_even;
        logic       par_odd;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] data;
    logic [7:0] io_in;
    logic [7:0] out_main;
    logic [7:0] out_odd;
    logic [7:0] out_fast;

    int   total;
    int   bad;
    logic exp_tgl;
    vec_t vecs[5];

    assign io_in = {data, start, rst_n, clk};

    pattern_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut (
        .io_in (io_in),
        .io_out(out_main)
    );

    pattern_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_odd (
        .io_in (io_in),
        .io_out(out_odd)
    );

    pattern_serial_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut_fast (
        .io_in (io_in),
        .io_out(out_fast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One frame on the main/odd (4 clk/bit) and fast (1 clk/bit) instances,
    // checked every cycle from the start edge to a few idle cycles after.
    task automatic apply_stimulus(input int i, input bit hold_start, input bit drop_edges);
        logic       bit_now;
        logic [2:0] idx;
        @(negedge clk);
        data  = vecs[i].data;
        start = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j < 32) begin
                bit_now = vecs[i].seq[j / 4];
                idx     = (j >= 4 && j < 24) ? 3'(j / 4 - 1) : 3'd0;
                check_output("tx", {7'd0, out_main[0]}, {7'd0, bit_now});
                check_output("busy", {7'd0, out_main[1]}, 8'd1);
                check_output("done_low", {7'd0, out_main[2]}, 8'd0);
                check_output("bit_idx", {5'd0, out_main[5:3]}, {5'd0, idx});
                check_output("par", {7'd0, out_main[6]}, {7'd0, vecs[i].par_even});
                check_output("tgl_hold", {7'd0, out_main[7]}, {7'd0, exp_tgl});
                check_output("odd_par", {7'd0, out_odd[6]}, {7'd0, vecs[i].par_odd});
                check_output("odd_tx", {7'd0, out_odd[0]},
                             {7'd0, (j >= 24 && j < 28) ? vecs[i].par_odd : bit_now});
                if (j < 8)
                    check_output("fast_tx", {7'd0, out_fast[0]}, {7'd0, vecs[i].seq[j]});
                if (j == 8)
                    check_output("fast_end", {6'd0, out_fast[2:1]}, 8'b10);
            end else if (j == 32) begin
                exp_tgl = ~exp_tgl;
                check_output("frame_end", {out_main[7], out_main[5:0]},
                             {1'b0, exp_tgl, 3'd0, 1'b1, 1'b0, 1'b1});
            end else begin
                check_output("idle_after", {5'd0, out_main[2:0]}, 8'b001);
            end
            if (j == 5) data = ~vecs[i].data;
            if (!hold_start) start = (drop_edges && (j == 9 || j == 31));
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_tgl = 1'b0;

        vecs[0] = '{data: 5'b10110, seq: 8'b00110111, par_even: 1'b1, par_odd: 1'b0};
        vecs[1] = '{data: 5'b00001, seq: 8'b01000011, par_even: 1'b1, par_odd: 1'b0};
        vecs[2] = '{data: 5'b11111, seq: 8'b01111111, par_even: 1'b1, par_odd: 1'b0};
        vecs[3] = '{data: 5'b00000, seq: 8'b00000001, par_even: 1'b0, par_odd: 1'b1};
        vecs[4] = '{data: 5'b01010, seq: 8'b00101001, par_even: 1'b0, par_odd: 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        data  = 5'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            data  = 5'($urandom_range(0, 31));
            #1;
            check_output("reset_main", out_main, 8'h01);
            check_output("reset_odd", out_odd, 8'h01);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_output("post_reset_idle", out_main, 8'h01);
        end

        for (int i = 0; i < 5; i++) apply_stimulus(i, 1'b0, 1'b0);

        apply_stimulus(0, 1'b0, 1'b1);

        apply_stimulus(1, 1'b1, 1'b0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            check_output("held_start_idle", {5'd0, out_main[2:0]}, 8'b001);
        end
        @(negedge clk);
        start = 1'b0;
        apply_stimulus(2, 1'b0, 1'b0);
        check_output("tgl_back_to_0", {7'd0, out_main[7]}, 8'd0);

        @(negedge clk);
        data  = 5'b10110;
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_output("pre_reset_bit_idx", {5'd0, out_main[5:3]}, 8'd2);
        rst_n = 1'b0;
        #1;
        check_output("async_reset", out_main, 8'h01);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_tgl = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_output("after_reset_idle", out_main, 8'h01);
        end
        apply_stimulus(1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
